// File: rtl/axis_marker_insert.sv
// ---------------------------------------------------------------------------
// axis_marker_insert
//
// Merges tagged marker words into an AXI-Stream event stream. A marker is
// requested either by a single-cycle pulse on marker_req or by a free-running
// period timer. Markers win arbitration over input data. Each marker carries
// the tag pattern (C_MARKER_VALUE & C_MARKER_MASK) in its upper bits and a
// 32-bit sequence number in its low bits. A downstream filter can then
// recognise the markers and strip them. Data words pass through unchanged.
// Data words that happen to match the tag are still forwarded, and they are
// counted in collision_count.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   s_axis_*           input stream (tvalid/tready/tdata)
//   m_axis_*           output stream, tvalid/tdata registered
//   marker_req         single-cycle marker request pulse
//   marker_seq         sequence number the next emitted marker will carry
//   collision_count    saturating count of forwarded data words matching tag
//
// Handshake: a word moves on a stream only in a cycle where tvalid=1 and
// tready=1. Once m_axis_tvalid is raised, m_axis_tvalid and m_axis_tdata stay
// unchanged until m_axis_tready is seen high. s_axis_tready depends only on
// the output register state, m_axis_tready and the pending flag. It never
// depends on s_axis_tvalid.
// ---------------------------------------------------------------------------
module axis_marker_insert #(
    parameter int                            C_AXIS_TDATA_WIDTH = 96,
    parameter logic [C_AXIS_TDATA_WIDTH-1:0] C_MARKER_MASK      = 96'h8000_0000_0000_0000_0000_0000,
    parameter logic [C_AXIS_TDATA_WIDTH-1:0] C_MARKER_VALUE     = 96'h8000_0000_0000_0000_0000_0000,
    parameter int unsigned                   C_PERIOD           = 0
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    input  logic                          marker_req,
    output logic [31:0]                   marker_seq,
    output logic [15:0]                   collision_count
);

    localparam logic [C_AXIS_TDATA_WIDTH-1:0] TAG = C_MARKER_VALUE & C_MARKER_MASK;
    localparam int TW = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;

    logic                          pending;
    logic                          timer_expiry;
    logic                          slot_free;
    logic                          load_marker;
    logic                          load_data;
    logic                          collision;
    logic [C_AXIS_TDATA_WIDTH-1:0] marker_word;

    // The output register can take a new word when it is empty or when its
    // current word is leaving this cycle.
    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign load_marker   = slot_free && pending;
    assign s_axis_tready = slot_free && !pending;
    assign load_data     = s_axis_tready && s_axis_tvalid;

    assign marker_word = TAG | {{(C_AXIS_TDATA_WIDTH-32){1'b0}}, marker_seq};
    assign collision   = (s_axis_tdata & C_MARKER_MASK) == TAG;

    // Free-running period timer. It expires on its last count and then wraps.
    if (C_PERIOD > 0) begin : g_timer
        logic [TW-1:0] timer;

        assign timer_expiry = (timer == TW'(C_PERIOD - 1));

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                timer <= '0;
            end else if (timer_expiry) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end else begin : g_no_timer
        assign timer_expiry = 1'b0;
    end

    // A request that arrives while a marker is being loaded re-arms pending,
    // so one more marker follows. Requests that arrive while pending is
    // already set are merged into it and are not queued.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending <= 1'b0;
        end else begin
            pending <= (pending && !load_marker) || marker_req || timer_expiry;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid   <= 1'b0;
            m_axis_tdata    <= '0;
            marker_seq      <= '0;
            collision_count <= '0;
        end else begin
            if (load_marker) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= marker_word;
                marker_seq    <= marker_seq + 32'd1;
            end else if (load_data) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                if (collision && (collision_count != 16'hFFFF)) begin
                    collision_count <= collision_count + 16'd1;
                end
            end else if (slot_free) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_marker_insert.sv
// ---------------------------------------------------------------------------
// tb_axis_marker_insert
//
// dut0 has the timer disabled and receives directed and random stream
// traffic. dut1 runs with C_PERIOD=8 and an idle input.
// A reference model is stepped once per cycle at the falling edge. It
// derives the expected output from the arbitration rules. A scoreboard queue
// holds the words the model expects dut0 to emit, in order.
// ---------------------------------------------------------------------------
module tb_axis_marker_insert;

    localparam int W = 96;
    localparam logic [W-1:0] TAG = 96'h8000_0000_0000_0000_0000_0000;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- DUT signals ----------------
    logic         s_tvalid0, s_tready0, m_tvalid0, m_tready0, req0;
    logic [W-1:0] s_tdata0, m_tdata0;
    logic [31:0]  seq0;
    logic [15:0]  coll0;

    logic         s_tvalid1, s_tready1, m_tvalid1, m_tready1, req1;
    logic [W-1:0] s_tdata1, m_tdata1;
    logic [31:0]  seq1;
    logic [15:0]  coll1;

    axis_marker_insert #(.C_PERIOD(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0), .s_axis_tdata(s_tdata0),
        .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready0), .m_axis_tdata(m_tdata0),
        .marker_req(req0), .marker_seq(seq0), .collision_count(coll0)
    );

    axis_marker_insert #(.C_PERIOD(8)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1), .s_axis_tdata(s_tdata1),
        .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1), .m_axis_tdata(m_tdata1),
        .marker_req(req1), .marker_seq(seq1), .collision_count(coll1)
    );

    // ---------------- check task ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic         mdl_valid[2];
    logic [W-1:0] mdl_data[2];
    logic         mdl_pending[2];
    logic [31:0]  mdl_seq[2];
    logic [15:0]  mdl_coll[2];
    int           mdl_cyc[2];

    logic [W-1:0] exp_q[$];     // words dut0 must emit, in order
    int           mk_cyc[$];    // dut1: model cycle at which each marker left
    logic [31:0]  mk_low[$];    // dut1: low 32 bits of each marker

    logic acc0 = 1'b0;          // dut0 input word accepted at the last edge
    int   stall0 = 0;           // dut0 cycles with s_axis_tready low

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_valid[d]   = 1'b0;
            mdl_data[d]    = '0;
            mdl_pending[d] = 1'b0;
            mdl_seq[d]     = '0;
            mdl_coll[d]    = '0;
            mdl_cyc[d]     = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_cycle(input int d, input logic sv, input logic [W-1:0] sd,
                               input logic mr, input logic rq,
                               input logic dut_sr, input logic dut_mv,
                               input logic [W-1:0] dut_md, input logic [31:0] dut_seq,
                               input logic [15:0] dut_coll);
        int    period;
        logic  free, ld_mk, hit;
        string pre;
        period = (d == 0) ? 0 : 8;
        pre    = (d == 0) ? "d0" : "d1";
        free   = !mdl_valid[d] || mr;

        check({pre, "_m_tvalid"}, W'(dut_mv), W'(mdl_valid[d]));
        if (mdl_valid[d]) check({pre, "_m_tdata"}, dut_md, mdl_data[d]);
        check({pre, "_s_tready"}, W'(dut_sr), W'(free && !mdl_pending[d]));
        check({pre, "_marker_seq"}, W'(dut_seq), W'(mdl_seq[d]));
        check({pre, "_collision_count"}, W'(dut_coll), W'(mdl_coll[d]));
        if (!aresetn) return;

        if (d == 0 && dut_mv && mr) begin
            if (exp_q.size() == 0) check("d0_sb_extra", W'(dut_mv), W'(0));
            else                   check("d0_sb_word", dut_md, exp_q.pop_front());
        end
        if (d == 1 && dut_mv && mr && ((dut_md & TAG) == TAG)) begin
            mk_cyc.push_back(mdl_cyc[1]);
            mk_low.push_back(dut_md[31:0]);
        end

        ld_mk = free && mdl_pending[d];
        if (ld_mk) begin
            mdl_valid[d] = 1'b1;
            mdl_data[d]  = TAG | W'(mdl_seq[d]);
            mdl_seq[d]   = mdl_seq[d] + 1;
            if (d == 0) exp_q.push_back(mdl_data[d]);
        end else if (free && sv) begin
            mdl_valid[d] = 1'b1;
            mdl_data[d]  = sd;
            if (((sd & TAG) == TAG) && (mdl_coll[d] != 16'hFFFF)) mdl_coll[d] = mdl_coll[d] + 1;
            if (d == 0) exp_q.push_back(sd);
        end else if (free) begin
            mdl_valid[d] = 1'b0;
        end
        hit = (period > 0) && ((mdl_cyc[d] % period) == period - 1);
        mdl_pending[d] = (mdl_pending[d] && !ld_mk) || rq || hit;
        mdl_cyc[d]++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge aclk);
        if (aresetn && !s_tready0) stall0++;
        model_cycle(0, s_tvalid0, s_tdata0, m_tready0, req0, s_tready0, m_tvalid0, m_tdata0, seq0, coll0);
        model_cycle(1, s_tvalid1, s_tdata1, m_tready1, req1, s_tready1, m_tvalid1, m_tdata1, seq1, coll1);
        acc0 = s_tvalid0 && s_tready0;
        @(posedge aclk);
        #1;
    endtask

    // Present a new word on dut0 only once the previous one was taken.
    task automatic offer(input logic [W-1:0] d);
        if (!s_tvalid0 || acc0) begin
            s_tvalid0 = 1'b1;
            s_tdata0  = d;
        end
    endtask

    // Wait until the current word is taken, then drop tvalid. Bounded wait.
    task automatic idle_src();
        for (int i = 0; i < 200 && s_tvalid0 && !acc0; i++) step();
        if (s_tvalid0 && !acc0) check("idle_timeout", W'(acc0), W'(1));
        s_tvalid0 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int n0, st0;

    initial begin
        s_tvalid0 = 0; s_tdata0 = '0; m_tready0 = 1; req0 = 0;
        s_tvalid1 = 0; s_tdata1 = '0; m_tready1 = 1; req1 = 0;
        model_reset();

        // Reset state
        #2;
        check("rst_m_tvalid", W'(m_tvalid0), W'(0));
        check("rst_m_tdata", m_tdata0, '0);
        check("rst_seq", W'(seq0), W'(0));
        check("rst_coll", W'(coll0), W'(0));
        repeat (3) step();
        aresetn = 1'b1;

        // Pass-through 1, 2, 3
        for (int i = 1; i <= 3; i++) begin
            offer(W'(i));
            step();
        end
        idle_src();
        repeat (3) step();
        check("pt_coll", W'(coll0), W'(0));

        // Request while data streams
        st0 = stall0;
        for (int i = 0; i < 8; i++) begin
            offer(W'(16 + i));
            req0 = (i == 3);
            step();
        end
        req0 = 0;
        idle_src();
        repeat (3) step();
        check("req_stall", W'(stall0 - st0), W'(1));
        check("req_seq", W'(seq0), W'(1));

        // Backpressure while holding 0x5
        m_tready0 = 0;
        offer(W'(5));
        step();
        offer(W'(6));
        for (int i = 0; i < 5; i++) begin
            req0 = (i == 0);
            step();
            check("bp_hold", m_tdata0, W'(5));
        end
        req0 = 0;
        m_tready0 = 1;
        idle_src();
        repeat (4) step();

        // Collision word is forwarded and counted
        offer(TAG | W'(5));
        step();
        idle_src();
        repeat (2) step();
        check("coll_one", W'(coll0), W'(1));

        // dut1 periodic markers, with no extra requests so far
        check("per_n", W'(mk_cyc.size() >= 3), W'(1));
        if (mk_cyc.size() >= 3) begin
            check("per_first", W'(mk_cyc[0]), W'(9));
            for (int i = 0; i < 3; i++) check("per_low", W'(mk_low[i]), W'(i));
            for (int i = 1; i < 3; i++) check("per_gap", W'(mk_cyc[i] - mk_cyc[i-1]), W'(8));
        end

        // A request that coincides with timer expiry merges into that marker
        for (int i = 0; i < 8 && (mdl_cyc[1] % 8) != 7; i++) step();
        n0 = mk_cyc.size();
        req1 = 1;
        step();
        req1 = 0;
        repeat (16) step();
        check("merge_cnt", W'(mk_cyc.size() - n0), W'(2));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            m_tready0 = ($urandom_range(0, 3) != 0);
            req0      = ($urandom_range(0, 15) == 0);
            if (!s_tvalid0 || acc0) begin
                if ($urandom_range(0, 3) != 0) begin
                    s_tvalid0 = 1'b1;
                    s_tdata0  = {$urandom, $urandom, $urandom};
                    s_tdata0[95] = ($urandom_range(0, 7) == 0);
                end else begin
                    s_tvalid0 = 1'b0;
                end
            end
            step();
        end
        req0 = 0;
        m_tready0 = 1;
        idle_src();
        repeat (3) step();

        // Collision counter saturation
        for (int i = 0; i < 65540; i++) begin
            offer(TAG | W'(i));
            step();
        end
        idle_src();
        repeat (2) step();
        check("coll_sat", W'(coll0), W'(16'hFFFF));

        // Asynchronous reset while the output holds a word
        m_tready0 = 0;
        offer(W'(7));
        step();
        s_tvalid0 = 0;
        step();
        check("pre_rst_valid", W'(m_tvalid0), W'(1));
        #2;
        aresetn = 1'b0;
        #1;
        check("async_m_tvalid", W'(m_tvalid0), W'(0));
        check("async_seq", W'(seq0), W'(0));
        check("async_coll", W'(coll0), W'(0));
        check("async_m_tvalid1", W'(m_tvalid1), W'(0));
        model_reset();
        acc0 = 0;
        m_tready0 = 1;
        repeat (2) step();
        aresetn = 1'b1;
        req0 = 1;
        step();
        req0 = 0;
        repeat (4) step();
        check("post_rst_seq", W'(seq0), W'(1));
        check("post_rst_sb", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
